conv_layer_seq: RTL and testbench

//  Sequencer for one convolution layer of the CNN datapath, clocked on clk. Walks kernel taps, output

---
 rtl/conv_layer_seq.sv | 131 +++++++++++++
 tb/tb_conv_layer_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_seq.sv
// Convolution layer sequencer: walks taps, output pixels and output planes, drives the MAC
// controls and issues delayed write strobes with their output address.
module conv_layer_seq #(
  parameter int KSIZE        = 5,
  parameter int CH_GROUPS    = 1,
  parameter int PLANE_PIX    = 784,
  parameter int OUT_PLANES   = 6,
  parameter int PLANE_STRIDE = 196,
  parameter int WRITE_DELAY  = 2,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tap_valid,
  output logic              mac_en,
  output logic              acc_clr,
  output logic [7:0]        tap_idx,
  output logic              neuron_rdy,
  output logic              write_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic              plane_rdy,
  output logic              busy,
  output logic              done
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | stepping taps on tap_valid
  // DRAIN | final neuron's write still in the delay pipe
  // DONE  | one cycle, done asserted
  localparam int TAPS  = CH_GROUPS * KSIZE * KSIZE;
  localparam int PIX_W = (PLANE_PIX > 1) ? $clog2(PLANE_PIX) : 1;
  localparam int PLN_W = (OUT_PLANES > 1) ? $clog2(OUT_PLANES) : 1;
  localparam int DLY_W = $clog2(WRITE_DELAY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]        tap_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [PLN_W-1:0]  plane_cnt;
  logic [ADDR_W-1:0] base;
  logic [DLY_W-1:0]  drain_cnt;

  // Stage 0 of the pipe is neuron_rdy itself; write strobes load from the last stage.
  logic [WRITE_DELAY-1:0] pv;
  logic [WRITE_DELAY-1:0] pl;
  logic [ADDR_W-1:0]      pa [WRITE_DELAY];

  logic last_tap, last_pix, last_plane, neuron_evt;

  assign last_tap   = (tap_cnt == 8'(TAPS - 1));
  assign last_pix   = (pix_cnt == PIX_W'(PLANE_PIX - 1));
  assign last_plane = (plane_cnt == PLN_W'(OUT_PLANES - 1));
  assign mac_en     = (state == RUN) && tap_valid;
  assign acc_clr    = mac_en && (tap_cnt == 8'd0);
  assign tap_idx    = tap_cnt;
  assign neuron_evt = mac_en && last_tap;
  assign neuron_rdy = pv[0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (neuron_evt && last_pix && last_plane) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DLY_W'(WRITE_DELAY)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      pix_cnt   <= '0;
      plane_cnt <= '0;
      base      <= '0;
      drain_cnt <= '0;
      pv        <= '0;
      pl        <= '0;
      for (int i = 0; i < WRITE_DELAY; i++) pa[i] <= '0;
      write_rdy <= 1'b0;
      plane_rdy <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state_nxt == DONE);

      if (state == IDLE && start) begin
        tap_cnt   <= '0;
        pix_cnt   <= '0;
        plane_cnt <= '0;
        base      <= '0;
      end

      if (mac_en) begin
        if (last_tap) begin
          tap_cnt <= '0;
          if (last_pix) begin
            pix_cnt   <= '0;
            plane_cnt <= last_plane ? '0 : plane_cnt + 1'b1;
            base      <= base + ADDR_W'(PLANE_STRIDE);
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end else begin
          tap_cnt <= tap_cnt + 8'd1;
        end
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      pv[0] <= neuron_evt;
      pl[0] <= last_pix;
      pa[0] <= base + ADDR_W'(pix_cnt);
      for (int i = 1; i < WRITE_DELAY; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        pa[i] <= pa[i-1];
      end

      write_rdy <= pv[WRITE_DELAY-1];
      plane_rdy <= pv[WRITE_DELAY-1] && pl[WRITE_DELAY-1];
      if (pv[WRITE_DELAY-1]) out_addr <= pa[WRITE_DELAY-1];
    end
  end
endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: three configurations (base, address wrap, single tap) with a
// write scoreboard and a vector table for the per-tap MAC controls.
module tb_conv_layer_seq;
  typedef struct {
    int addr;
    bit plane;
  } exp_t;

  typedef struct {
    bit tv;
    bit mac;
    bit clr;
    int idx;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tap_valid;
  logic [2:0] start_v, mac_en_v, acc_clr_v, neuron_v, write_v, plane_v, busy_v, done_v;
  logic [7:0]  tap_idx_v [3];
  logic [15:0] addr_v    [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t expq [3][$];
  int   nq   [3][$];
  int writes [3];
  int dones  [3];
  int n_last [3];
  int w_last [3];
  int exp_period [3];
  int exp_wgap   [3];

  conv_layer_seq #(.KSIZE(2), .CH_GROUPS(1), .PLANE_PIX(3), .OUT_PLANES(2),
                   .PLANE_STRIDE(8), .WRITE_DELAY(2), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .tap_valid(tap_valid),
    .mac_en(mac_en_v[0]), .acc_clr(acc_clr_v[0]), .tap_idx(tap_idx_v[0]),
    .neuron_rdy(neuron_v[0]), .write_rdy(write_v[0]), .out_addr(addr_v[0]),
    .plane_rdy(plane_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  conv_layer_seq #(.KSIZE(2), .CH_GROUPS(1), .PLANE_PIX(3), .OUT_PLANES(3),
                   .PLANE_STRIDE(32'h8000), .WRITE_DELAY(2), .ADDR_W(16)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .tap_valid(tap_valid),
    .mac_en(mac_en_v[1]), .acc_clr(acc_clr_v[1]), .tap_idx(tap_idx_v[1]),
    .neuron_rdy(neuron_v[1]), .write_rdy(write_v[1]), .out_addr(addr_v[1]),
    .plane_rdy(plane_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  conv_layer_seq #(.KSIZE(1), .CH_GROUPS(1), .PLANE_PIX(3), .OUT_PLANES(2),
                   .PLANE_STRIDE(8), .WRITE_DELAY(2), .ADDR_W(16)) dut_t1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .tap_valid(tap_valid),
    .mac_en(mac_en_v[2]), .acc_clr(acc_clr_v[2]), .tap_idx(tap_idx_v[2]),
    .neuron_rdy(neuron_v[2]), .write_rdy(write_v[2]), .out_addr(addr_v[2]),
    .plane_rdy(plane_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write scoreboard and pulse timing monitor for all three instances.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (neuron_v[k]) begin
        if (exp_period[k] != 0 && n_last[k] >= 0)
          check($sformatf("neuron_period[%0d]", k), cyc - n_last[k], exp_period[k]);
        n_last[k] = cyc;
        nq[k].push_back(cyc);
      end
      if (write_v[k]) begin
        exp_t e;
        writes[k]++;
        if (expq[k].size() == 0) begin
          check($sformatf("unexpected_write[%0d]", k), 1, 0);
        end else begin
          e = expq[k].pop_front();
          check($sformatf("out_addr[%0d]", k), int'(addr_v[k]), e.addr);
          check($sformatf("plane_rdy[%0d]", k), int'(plane_v[k]), int'(e.plane));
        end
        if (nq[k].size() == 0) check($sformatf("write_without_neuron[%0d]", k), 1, 0);
        else check($sformatf("write_delay[%0d]", k), cyc - nq[k].pop_front(), 2);
        if (exp_wgap[k] != 0 && w_last[k] >= 0)
          check($sformatf("write_gap[%0d]", k), cyc - w_last[k], exp_wgap[k]);
        w_last[k] = cyc;
      end else if (plane_v[k]) begin
        check($sformatf("stray_plane_rdy[%0d]", k), 1, 0);
      end
      if (done_v[k]) dones[k]++;
    end
  end

  task automatic push_layer(input int k, input int planes, input int stride);
    for (int p = 0; p < planes; p++) begin
      for (int x = 0; x < 3; x++) begin
        exp_t e;
        e.addr  = (p * stride + x) & 32'hFFFF;
        e.plane = (x == 2);
        expq[k].push_back(e);
      end
    end
  endtask

  task automatic run_layer(input int k, input bit do_start, input bit toggle,
                           input bit hold_start, input int stop_writes);
    int d0;
    int w0;
    bit fin;
    d0  = dones[k];
    w0  = writes[k];
    fin = 1'b0;
    if (do_start) begin
      @(posedge clk); #1;
      start_v[k] = 1'b1;
      tap_valid  = !toggle;
      @(negedge clk); #1;
      check("mac_en_idle", int'(mac_en_v[k]), 0);
    end
    for (int i = 0; i < 200 && !fin; i++) begin
      @(posedge clk); #1;
      start_v[k] = hold_start && (i >= 10);
      tap_valid  = toggle ? ~tap_valid : 1'b1;
      @(negedge clk); #1;
      if (dones[k] != d0) fin = 1'b1;
      if (stop_writes != 0 && writes[k] - w0 >= stop_writes) fin = 1'b1;
    end
    check("layer_progress_timeout", int'(fin), 1);
    if (hold_start) begin
      @(posedge clk); #1;
    end
    start_v[k] = 1'b0;
    if (stop_writes == 0) begin
      tap_valid = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("done_count", dones[k] - d0, 1);
      check("write_count", writes[k] - w0, 6 + 3 * int'(k == 1));
      check("busy_after", int'(busy_v[k]), 0);
      check("mac_en_after", int'(mac_en_v[k]), 0);
      check("exp_left", expq[k].size(), 0);
    end
  endtask

  vec_t vt [9];
  int   w_hold;

  initial begin
    for (int k = 0; k < 3; k++) begin
      writes[k] = 0; dones[k] = 0; n_last[k] = -1; w_last[k] = -1;
      exp_period[k] = 0; exp_wgap[k] = 0;
    end
    vt[0] = '{1, 1, 1, 0}; vt[1] = '{0, 0, 0, 1}; vt[2] = '{1, 1, 0, 1};
    vt[3] = '{0, 0, 0, 2}; vt[4] = '{1, 1, 0, 2}; vt[5] = '{0, 0, 0, 3};
    vt[6] = '{1, 1, 0, 3}; vt[7] = '{0, 0, 0, 0}; vt[8] = '{1, 1, 1, 0};

    rst_n = 1'b0; start_v = '0; tap_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    check("rst_write", int'(write_v[0]), 0);
    check("rst_addr", int'(addr_v[0]), 0);
    check("rst_mac_en", int'(mac_en_v[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: continuous taps
    exp_period[0] = 4;
    push_layer(0, 2, 8);
    run_layer(0, 1'b1, 1'b0, 1'b0, 0);
    exp_period[0] = 0;

    // 2: alternating tap_valid, table of per-cycle MAC controls
    push_layer(0, 2, 8);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    tap_valid  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      tap_valid  = vt[i].tv;
      @(negedge clk); #1;
      check($sformatf("vec%0d_mac_en", i), int'(mac_en_v[0]), int'(vt[i].mac));
      check($sformatf("vec%0d_acc_clr", i), int'(acc_clr_v[0]), int'(vt[i].clr));
      check($sformatf("vec%0d_tap_idx", i), int'(tap_idx_v[0]), vt[i].idx);
    end
    run_layer(0, 1'b0, 1'b1, 1'b0, 0);

    // 3: start held high from mid-layer through DONE
    push_layer(0, 2, 8);
    run_layer(0, 1'b1, 1'b0, 1'b1, 0);

    // 4: reset one cycle after the second write, then a fresh layer
    push_layer(0, 2, 8);
    run_layer(0, 1'b1, 1'b0, 1'b0, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tap_valid = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_mac_en", int'(mac_en_v[0]), 0);
    check("mid_rst_acc_clr", int'(acc_clr_v[0]), 0);
    check("mid_rst_tap_idx", int'(tap_idx_v[0]), 0);
    check("mid_rst_neuron", int'(neuron_v[0]), 0);
    check("mid_rst_write", int'(write_v[0]), 0);
    check("mid_rst_addr", int'(addr_v[0]), 0);
    check("mid_rst_plane", int'(plane_v[0]), 0);
    check("mid_rst_busy", int'(busy_v[0]), 0);
    check("mid_rst_done", int'(done_v[0]), 0);
    expq[0].delete();
    nq[0].delete();
    w_hold = writes[0];
    repeat (8) @(negedge clk);
    #1;
    check("no_write_after_rst", writes[0] - w_hold, 0);
    push_layer(0, 2, 8);
    run_layer(0, 1'b1, 1'b0, 1'b0, 0);

    // 5: plane base wraps modulo 2^16
    push_layer(1, 3, 32'h8000);
    run_layer(1, 1'b1, 1'b0, 1'b0, 0);

    // 6: single tap per neuron, back-to-back writes
    exp_period[2] = 1;
    exp_wgap[2]   = 1;
    push_layer(2, 2, 8);
    run_layer(2, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
